// File: rtl/sync_fifo_param.sv
// sync_fifo_param: FWFT synchronous FIFO with occupancy count, threshold and sticky interrupts.
// Define SYNC_FIFO_OVERWRITE_EN to let a write into a full FIFO replace the oldest entry.
module sync_fifo_param #(
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_fifo_en,
    input  logic          i_wr_en,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_rd_en,
    output logic [DW-1:0] o_rd_data,
    output logic [AW:0]   o_count,
    output logic          o_empty,
    output logic          o_full,
    input  logic [AW:0]   i_thold,
    input  logic          i_intr_edge,
    input  logic [4:0]    i_intr_en,
    input  logic [4:0]    i_intr_clr,
    output logic [4:0]    o_intr_status,
    output logic          o_intr
);
    localparam logic [AW:0] L_DEPTH = (AW+1)'(1 << AW);
    localparam logic [AW:0] L_ONE   = (AW+1)'(1);

    logic [DW-1:0] r_mem [1 << AW];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;
    logic [4:0]    r_status;
    logic          w_full, w_empty, w_wacc, w_racc, w_ovf, w_udf, w_ovw, w_thold_hit;

    assign w_full  = r_count == L_DEPTH;
    assign w_empty = r_count == '0;
    assign w_ovf   = i_fifo_en & i_wr_en & w_full & ~i_rd_en;
    assign w_udf   = i_fifo_en & i_rd_en & w_empty;
`ifdef SYNC_FIFO_OVERWRITE_EN
    assign w_ovw   = w_ovf;
`else
    assign w_ovw   = 1'b0;
`endif
    assign w_wacc  = (i_fifo_en & i_wr_en & (~w_full | i_rd_en)) | w_ovw;
    assign w_racc  = i_fifo_en & i_rd_en & ~w_empty;
    assign w_thold_hit = (i_thold != '0) & (i_intr_edge ? r_count >= i_thold : r_count <= i_thold);

    always_ff @(posedge clk)
        if (w_wacc) r_mem[r_wr_ptr] <= i_wr_data;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_status <= '0;
        end else begin
            // Clear and disable win over a condition that is true on the same edge
            r_status <= (r_status | {w_ovf, w_udf, w_full, w_empty, w_thold_hit}) & i_intr_en & ~i_intr_clr;
            if (!i_fifo_en) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_wacc) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_racc | w_ovw) r_rd_ptr <= r_rd_ptr + 1'b1;
                if (w_wacc & ~w_racc & ~w_ovw) r_count <= r_count + L_ONE;
                else if (w_racc & ~w_wacc) r_count <= r_count - L_ONE;
            end
        end

    assign o_rd_data     = r_mem[r_rd_ptr];
    assign o_count       = r_count;
    assign o_empty       = w_empty;
    assign o_full        = w_full;
    assign o_intr_status = r_status;
    assign o_intr        = |r_status;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed and random stimulus against a queue-based model of the FIFO.
module tb_sync_fifo_param;
    localparam int DW = 16, AW = 4, DEPTH = 16;
    logic clk = 0, rst_n = 0;
    always #5 clk = ~clk;

    logic          fe = 0, we = 0, re = 0, ie = 0;
    logic [DW-1:0] wd = 0;
    logic [AW:0]   th = 0;
    logic [4:0]    en = 0, clr = 0;
    logic [DW-1:0] rdd;
    logic [AW:0]   cnt;
    logic          emp, ful, irq;
    logic [4:0]    st;

    logic [DW-1:0] q[$];
    logic [4:0]    mst = 0;
    int            n_chk = 0, n_pass = 0;

    sync_fifo_param #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .i_fifo_en(fe), .i_wr_en(we), .i_wr_data(wd),
        .i_rd_en(re), .o_rd_data(rdd), .o_count(cnt), .o_empty(emp), .o_full(ful),
        .i_thold(th), .i_intr_edge(ie), .i_intr_en(en), .i_intr_clr(clr),
        .o_intr_status(st), .o_intr(irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all();
        chk("count", 32'(cnt), 32'(q.size()));
        chk("empty", 32'(emp), 32'(q.size() == 0));
        chk("full", 32'(ful), 32'(q.size() == DEPTH));
        chk("status", 32'(st), 32'(mst));
        chk("intr", 32'(irq), 32'(mst != 0));
        if (q.size() != 0) chk("rd_data", 32'(rdd), 32'(q[0]));
    endtask

    task automatic cyc(input logic f, input logic w, input logic [DW-1:0] d, input logic r, input logic [4:0] c);
        logic full, empty, wacc, racc, ovf, udf, thit;
        fe = f; we = w; wd = d; re = r; clr = c;
        full  = q.size() == DEPTH;
        empty = q.size() == 0;
        wacc  = f & w & (!full | r);
        racc  = f & r & !empty;
        ovf   = f & w & full & !r;
        udf   = f & r & empty;
        thit  = (th != 0) && (ie ? q.size() >= int'(th) : q.size() <= int'(th));
        mst   = (mst | {ovf, udf, full, empty, thit}) & en & ~c;
        if (!f) q.delete();
        else begin
            if (racc) void'(q.pop_front());
            if (wacc) q.push_back(d);
`ifdef SYNC_FIFO_OVERWRITE_EN
            if (ovf) begin
                void'(q.pop_front());
                q.push_back(d);
            end
`endif
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        #12;
        chk("rst_count", 32'(cnt), 0);
        chk("rst_empty", 32'(emp), 1);
        chk("rst_full", 32'(ful), 0);
        chk("rst_status", 32'(st), 0);
        chk("rst_intr", 32'(irq), 0);
        rst_n = 1;
        // ordered fill and drain
        for (int i = 1; i <= 16; i++) cyc(1, 1, 16'(i), 0, 0);
        chk("fill_count", 32'(cnt), 16);
        chk("fill_full", 32'(ful), 1);
        chk("fill_empty", 32'(emp), 0);
        for (int i = 1; i <= 16; i++) begin
            chk("drain_data", 32'(rdd), 32'(i));
            cyc(1, 0, 0, 1, 0);
        end
        chk("drain_empty", 32'(emp), 1);
        chk("drain_count", 32'(cnt), 0);
        // overflow on a full FIFO
        for (int i = 1; i <= 16; i++) cyc(1, 1, 16'(i), 0, 0);
        en = 5'h10;
        cyc(1, 1, 16'hDEAD, 0, 0);
        chk("ovf_count", 32'(cnt), 16);
        chk("ovf_status", 32'(st[4]), 1);
        chk("ovf_intr", 32'(irq), 1);
`ifdef SYNC_FIFO_OVERWRITE_EN
        chk("ovf_head", 32'(rdd), 32'h0002);
`else
        chk("ovf_head", 32'(rdd), 32'h0001);
`endif
        for (int i = 0; i < 15; i++) cyc(1, 0, 0, 1, 0);
`ifdef SYNC_FIFO_OVERWRITE_EN
        chk("ovw_last", 32'(rdd), 32'hDEAD);
`endif
        cyc(1, 0, 0, 1, 0);
        // simultaneous read/write at empty and at full
        en = 5'h08;
        cyc(1, 1, 16'h00AA, 1, 0);
        chk("udf_count", 32'(cnt), 1);
        chk("udf_data", 32'(rdd), 32'h00AA);
        chk("udf_status", 32'(st[3]), 1);
        en = 5'h10;
        for (int i = 0; i < 15; i++) cyc(1, 1, 16'(i + 32), 0, 0);
        cyc(1, 1, 16'h0BEE, 1, 0);
        chk("rw_full_count", 32'(cnt), 16);
        chk("rw_full_noovf", 32'(st[4]), 0);
        // threshold source
        en = 0;
        cyc(0, 0, 0, 0, 0);
        en = 5'h01; th = 8; ie = 1;
        for (int i = 0; i < 8; i++) cyc(1, 1, 16'(i + 100), 0, 0);
        chk("th_lag", 32'(st[0]), 0);
        cyc(1, 0, 0, 0, 0);
        chk("th_set", 32'(st[0]), 1);
        cyc(1, 0, 0, 0, 5'h01);
        chk("th_clr", 32'(st[0]), 0);
        cyc(1, 0, 0, 0, 0);
        chk("th_reset", 32'(st[0]), 1);
        cyc(1, 1, 16'h0111, 0, 0);
        cyc(1, 1, 16'h0112, 0, 0);
        ie = 0;
        cyc(1, 0, 0, 0, 5'h01);
        cyc(1, 0, 0, 1, 0);
        cyc(1, 0, 0, 1, 0);
        chk("th_le_lag", 32'(st[0]), 0);
        cyc(1, 0, 0, 0, 0);
        chk("th_le_set", 32'(st[0]), 1);
        // flush keeps status, then pointer wrap
        th = 0; en = 0;
        cyc(0, 0, 0, 0, 0);
        en = 5'h08;
        cyc(1, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) cyc(1, 1, 16'(i + 200), 0, 0);
        cyc(0, 1, 16'h0F0F, 0, 0);
        chk("flush_count", 32'(cnt), 0);
        chk("flush_empty", 32'(emp), 1);
        chk("flush_status", 32'(st), 32'h08);
        cyc(1, 1, 16'h0300, 0, 0);
        for (int i = 1; i <= 20; i++) cyc(1, 1, 16'(i + 16'h0300), 1, 0);
        cyc(1, 0, 0, 1, 0);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            en = 5'($urandom);
            th = 5'($urandom_range(0, 16));
            ie = 1'($urandom);
            cyc($urandom_range(0, 15) != 0, 1'($urandom), 16'($urandom), 1'($urandom),
                ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h0);
        end
        // async reset mid-burst
        en = 0; th = 0;
        cyc(0, 0, 0, 0, 0);
        en = 5'h02;
        for (int i = 0; i < 9; i++) cyc(1, 1, 16'(i + 500), 0, 0);
        chk("pre_rst_count", 32'(cnt), 9);
        chk("pre_rst_intr", 32'(irq), 1);
        we = 1;
        #3 rst_n = 0;
        #1;
        q.delete();
        mst = 0;
        chk("arst_count", 32'(cnt), 0);
        chk("arst_empty", 32'(emp), 1);
        chk("arst_full", 32'(ful), 0);
        chk("arst_intr", 32'(irq), 0);
        #3 rst_n = 1;
        en = 0;
        cyc(1, 1, 16'h0777, 0, 0);
        cyc(1, 0, 0, 1, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous FIFO with first-word-fall-through read, an exact occupancy counter, a programmable occupancy threshold and a five-source sticky interrupt block with a single combined interrupt line. It is the general-purpose buffer for peripheral data paths (UART/SPI/I2S), where software programs the threshold and services the interrupts. One clock domain.

## Interface
- DW, 16, data width in bits
- AW, 4, address width; DEPTH = 2**AW entries (AW >= 2)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- fifo_en  in  1  block enable; low = synchronous flush
- wr_en  in  1  write request
- wr_data  in  DW  write data
- rd_en  in  1  read request (pop)
- rd_data  out  DW  head entry, combinational from storage
- count  out  AW+1  occupancy, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- thold  in  AW+1  threshold level; 0 disables the threshold source
- intr_edge  in  1  1: threshold fires at count >= thold; 0: at count <= thold
- intr_en  in  5  per-source enable; bit0 thold, bit1 empty, bit2 full, bit3 underflow, bit4 overflow
- intr_clr  in  5  per-source clear, write-one pulse
- intr_status  out  5  sticky status, same bit map
- intr  out  1  OR of intr_status

## Operation
- Storage: DEPTH x DW array, wr_ptr and rd_ptr of AW bits, natural wrap from DEPTH-1 to 0.
- Write accepted (wacc) = fifo_en & wr_en & (~full | rd_en). Read accepted (racc) = fifo_en & rd_en & ~empty.
- wacc: mem[wr_ptr] <= wr_data, wr_ptr + 1. racc: rd_ptr + 1.
- count: +1 on wacc only, -1 on racc only, unchanged on both or neither. It never exceeds DEPTH and never underflows.
- Full with rd_en and wr_en both high: both accepted, count stays DEPTH, no overflow.
- Empty with rd_en and wr_en both high: write accepted, read rejected (underflow), count becomes 1.
- Rejected write (fifo_en & wr_en & ~wacc): data dropped, no pointer or count change.
- Rejected read (fifo_en & rd_en & empty): no state change.
- empty and full are decoded from the count register, so they never lag count.
- rd_data = mem[rd_ptr]. It is valid whenever empty = 0. Its value while empty is undefined and must not be checked.
- fifo_en = 0: wr_ptr, rd_ptr and count go to 0 on the next edge, and writes are blocked. Memory contents are not cleared. intr_status is not cleared.
- Interrupt bit i:
  - Clear has priority: it goes to 0 if intr_clr[i] is high or intr_en[i] is low.
  - Otherwise it is set, and stays set, when its condition is true at the edge.
  - Conditions: thold_hit, empty, full, underflow event, overflow event.
- thold_hit = (thold != 0) & (intr_edge ? count >= thold : count <= thold). The comparison is unsigned at AW+1 bits.

## Timing
- Reset values: count = 0, empty = 1, full = 0, intr_status = 0, intr = 0. rd_data is undefined.
- Write at edge k: count, empty and full update at edge k. The data is visible on rd_data after edge k if the FIFO was empty.
- Read at edge k: rd_data shows the next entry after edge k. There is no read latency beyond this combinational head.
- Level sources (thold, empty, full) set status one edge after the condition appears on count, empty or full.
- Event sources (underflow, overflow) set status on the same edge at which the rejected request is sampled.
- intr is combinational from intr_status.
- rst_n asserted mid-operation: all registers go to reset values immediately. Stored data is lost logically.

## Configuration
- SYNC_FIFO_OVERWRITE_EN defined:
  - A write while full with no read is accepted.
  - mem[wr_ptr] is overwritten, and wr_ptr and rd_ptr both advance, discarding the oldest entry.
  - count stays DEPTH.
  - The overflow status still sets.
- SYNC_FIFO_OVERWRITE_EN undefined: the write is dropped as described in Operation.

## Test plan
- Reset, DW=16 AW=4: write 0x0001..0x0010 on 16 consecutive cycles. Required: count 16, full=1, empty=0. Then read 16 cycles: data 0x0001..0x0010 in order, ending with empty=1 and count 0.
- Full FIFO, 17th write of 0xDEAD with intr_en=5'h10. Required without the macro: count 16, head 0x0001, intr_status[4]=1, intr=1. Required with the macro: head 0x0002 and the last entry 0xDEAD.
- Empty FIFO, rd_en and wr_en high together with wr_data 0x00AA. Required: count 1, rd_data 0x00AA, intr_status[3]=1. Then a full FIFO with rd_en and wr_en high: count stays 16 and no overflow.
- thold=8, intr_edge=1, intr_en[0]=1, fill to 8 entries. Required: status[0]=1 one cycle after count reaches 8. A clear pulse while count is still 8 re-sets the bit on the next edge. Set intr_edge=0 and drain to 8: the bit asserts again.
- Fill with 5 entries, drop fifo_en for one cycle. Required: count 0, empty=1, intr_status unchanged. Then 20 write/read pairs across the pointer wrap return data in order.
- Assert rst_n low mid-burst at count 9. Required: count 0, empty=1, full=0, intr=0 immediately, without waiting for a clock edge.
